// File: rtl/pair_sorter_if.sv
// Candidate-pair input stream and sorted-pair output stream
// of the K-smallest pair sorter.
interface pair_sorter_if #(
  parameter int NUM_POINTS = 1000,
  parameter int DIST_W     = 40
);
  localparam int IW = $clog2(NUM_POINTS);

  logic [IW-1:0]     pointa_in;
  logic [IW-1:0]     pointb_in;
  logic [DIST_W-1:0] dist_in;
  logic              pair_vld;
  logic              pair_last;
  logic              pair_rdy;
  logic [IW-1:0]     pointa_out;
  logic [IW-1:0]     pointb_out;
  logic              points_vld;
  logic              points_last;

  modport master (
    output pointa_in, pointb_in, dist_in,
    output pair_vld, pair_last,
    input  pair_rdy,
    input  pointa_out, pointb_out,
    input  points_vld, points_last
  );

  modport slave (
    input  pointa_in, pointb_in, dist_in,
    input  pair_vld, pair_last,
    output pair_rdy,
    output pointa_out, pointb_out,
    output points_vld, points_last
  );
endinterface

// File: rtl/pair_sorter.sv
// Streaming K-smallest pair selector: insertion-sorted buffer that
// drains in ascending distance order after the last pair of a batch.
module pair_sorter #(
  parameter int NUM_POINTS = 1000,
  parameter int NUM_PAIRS  = 1000,
  parameter int DIST_W     = 40
) (
  input  logic clk,
  input  logic rst,
  pair_sorter_if.slave bus
);
  localparam int IW = $clog2(NUM_POINTS);
  localparam int CW = $clog2(NUM_PAIRS + 1);
  localparam int K  = NUM_PAIRS;

  typedef enum logic {FILL, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     pa_q [K];
  logic [IW-1:0]     pa_d [K];
  logic [IW-1:0]     pb_q [K];
  logic [IW-1:0]     pb_d [K];
  logic [DIST_W-1:0] dist_q [K];
  logic [DIST_W-1:0] dist_d [K];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     oa_q, oa_d;
  logic [IW-1:0]     ob_q, ob_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;

  logic [K-1:0] lt;
  logic [K-1:0] lt_prev;
  logic         accept;

  assign bus.pair_rdy    = ~rst & (state_q == FILL);
  assign accept          = bus.pair_vld & bus.pair_rdy;
  assign bus.pointa_out  = oa_q;
  assign bus.pointb_out  = ob_q;
  assign bus.points_vld  = vld_q;
  assign bus.points_last = last_q;

  // lt[i]: new pair belongs before slot i; empty slots act as +inf
  always_comb begin
    lt = '0;
    for (int i = 0; i < K; i++) begin
      lt[i] = (i >= int'(cnt_q)) || (bus.dist_in < dist_q[i]);
    end
  end

  assign lt_prev = lt << 1;

  always_comb begin
    state_d = state_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    dist_d  = dist_q;
    cnt_d   = cnt_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 1; i < K; i++) begin
            if (lt[i-1]) begin
              pa_d[i]   = pa_q[i-1];
              pb_d[i]   = pb_q[i-1];
              dist_d[i] = dist_q[i-1];
            end
          end
          for (int i = 0; i < K; i++) begin
            if (lt[i] && !lt_prev[i]) begin
              pa_d[i]   = bus.pointa_in;
              pb_d[i]   = bus.pointb_in;
              dist_d[i] = bus.dist_in;
            end
          end
          if (int'(cnt_q) < K) cnt_d = cnt_q + CW'(1);
          if (bus.pair_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q != '0) begin
          oa_d   = pa_q[0];
          ob_d   = pb_q[0];
          vld_d  = 1'b1;
          last_d = (cnt_q == CW'(1));
          for (int i = 0; i < K - 1; i++) begin
            pa_d[i]   = pa_q[i+1];
            pb_d[i]   = pb_q[i+1];
            dist_d[i] = dist_q[i+1];
          end
          pa_d[K-1]   = '0;
          pb_d[K-1]   = '0;
          dist_d[K-1] = '1;
          cnt_d       = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FILL;
        end else begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < K; i++) begin
        pa_q[i]   <= '0;
        pb_q[i]   <= '0;
        dist_q[i] <= '1;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      for (int i = 0; i < K; i++) begin
        pa_q[i]   <= pa_d[i];
        pb_q[i]   <= pb_d[i];
        dist_q[i] <= dist_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pair_sorter.sv
// Self-checking bench for pair_sorter against a sorted-queue
// model of the K closest pairs.
module tb_pair_sorter;
  localparam int NP = 8;
  localparam int K  = 4;
  localparam int DW = 16;

  typedef struct {
    logic [2:0]    a;
    logic [2:0]    b;
    logic [DW-1:0] d;
  } pr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  pr_t model[$];

  pair_sorter_if #(.NUM_POINTS(NP), .DIST_W(DW)) bus ();

  pair_sorter #(
    .NUM_POINTS(NP),
    .NUM_PAIRS (K),
    .DIST_W    (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stable insert: after every entry of equal distance; keep K smallest
  function automatic void model_insert(input pr_t p);
    int pos;
    pos = model.size();
    for (int i = 0; i < model.size(); i++) begin
      if (model[i].d > p.d) begin
        pos = i;
        break;
      end
    end
    model.insert(pos, p);
    if (model.size() > K) void'(model.pop_back());
  endfunction

  task automatic send(input logic [2:0] a, input logic [2:0] b,
                      input logic [DW-1:0] d, input logic last);
    int n;
    pr_t p;
    @(negedge clk);
    bus.pointa_in = a;
    bus.pointb_in = b;
    bus.dist_in   = d;
    bus.pair_last = last;
    bus.pair_vld  = 1'b1;
    n = 0;
    while (bus.pair_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout rdy=%b required 1", bus.pair_rdy);
    end
    @(posedge clk);
    p.a = a;
    p.b = b;
    p.d = d;
    model_insert(p);
    #1;
    if (last) bus.pair_vld = 1'b0;
  endtask

  // Call just after the edge that accepted the last pair
  task automatic collect(input string tag);
    int n;
    pr_t e;
    n = model.size();
    @(negedge clk);
    checks++;
    if (bus.points_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s early_vld got %b required 0", tag, bus.points_vld);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = model.pop_front();
      checks++;
      if (bus.points_vld !== 1'b1 || bus.pointa_out !== e.a ||
          bus.pointb_out !== e.b || bus.points_last !== (k == n - 1)) begin
        errors++;
        $display("FAIL %s out%0d got vld=%b (%0d,%0d) last=%b required 1 (%0d,%0d) last=%b",
                 tag, k, bus.points_vld, bus.pointa_out, bus.pointb_out,
                 bus.points_last, e.a, e.b, (k == n - 1));
      end
      checks++;
      if (bus.pair_rdy !== (k == n - 1)) begin
        errors++;
        $display("FAIL %s rdy%0d got %b required %b",
                 tag, k, bus.pair_rdy, (k == n - 1));
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.pair_rdy !== 1'b0 || bus.points_vld !== 1'b0 ||
        bus.points_last !== 1'b0 || bus.pointa_out !== 3'd0 ||
        bus.pointb_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_outs got rdy=%b vld=%b last=%b a=%0d b=%0d required all 0",
               bus.pair_rdy, bus.points_vld, bus.points_last,
               bus.pointa_out, bus.pointb_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pair_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b required 1", bus.pair_rdy);
    end
    send(3'd1, 3'd2, 16'd40, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pair_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill_rdy got %b required 0", bus.pair_rdy);
    end
    bus.pair_vld = 1'b0;
    model.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send(3'd0, 3'd1, 16'd50, 1'b0);
    send(3'd2, 3'd3, 16'd10, 1'b0);
    send(3'd4, 3'd5, 16'd30, 1'b0);
    send(3'd6, 3'd7, 16'd20, 1'b1);
    collect("basic");
  endtask

  task automatic test_overflow();
    send(3'd0, 3'd1, 16'd60, 1'b0);
    send(3'd1, 3'd2, 16'd5, 1'b0);
    send(3'd2, 3'd3, 16'd40, 1'b0);
    send(3'd3, 3'd4, 16'd7, 1'b0);
    send(3'd4, 3'd5, 16'd100, 1'b0);
    send(3'd5, 3'd6, 16'd1, 1'b1);
    collect("overflow");
  endtask

  task automatic test_ties();
    send(3'd0, 3'd1, 16'd9, 1'b0);
    send(3'd2, 3'd3, 16'd9, 1'b0);
    send(3'd4, 3'd5, 16'd3, 1'b1);
    collect("ties");
  endtask

  task automatic test_hold_single();
    pr_t h;
    send(3'd1, 3'd1, 16'd12, 1'b0);
    send(3'd2, 3'd2, 16'd4, 1'b1);
    bus.pointa_in = 3'd5;
    bus.pointb_in = 3'd6;
    bus.dist_in   = 16'd77;
    bus.pair_last = 1'b1;
    bus.pair_vld  = 1'b1;
    collect("hold_drain");
    @(posedge clk);
    #1;
    bus.pair_vld = 1'b0;
    h.a = 3'd5;
    h.b = 3'd6;
    h.d = 16'd77;
    model_insert(h);
    collect("single");
  endtask

  task automatic test_reset_drain();
    pr_t e;
    send(3'd0, 3'd7, 16'd31, 1'b0);
    send(3'd1, 3'd6, 16'd11, 1'b0);
    send(3'd2, 3'd5, 16'd21, 1'b0);
    send(3'd3, 3'd4, 16'd1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = model.pop_front();
      checks++;
      if (bus.points_vld !== 1'b1 || bus.pointa_out !== e.a ||
          bus.pointb_out !== e.b) begin
        errors++;
        $display("FAIL rstdrain out%0d got vld=%b (%0d,%0d) required 1 (%0d,%0d)",
                 k, bus.points_vld, bus.pointa_out, bus.pointb_out, e.a, e.b);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.points_vld !== 1'b0 || bus.points_last !== 1'b0 ||
        bus.pointa_out !== 3'd0 || bus.pair_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rstdrain_clear got vld=%b last=%b a=%0d rdy=%b required 0",
               bus.points_vld, bus.points_last, bus.pointa_out, bus.pair_rdy);
    end
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    send(3'd1, 3'd2, 16'd8, 1'b0);
    send(3'd3, 3'd4, 16'd2, 1'b1);
    collect("after_rst");
  endtask

  task automatic test_random();
    int len;
    for (int bt = 0; bt < 8; bt++) begin
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             DW'($urandom_range(0, 15)), (j == len - 1));
      end
      collect("random");
    end
  endtask

  initial begin
    bus.pointa_in = '0;
    bus.pointb_in = '0;
    bus.dist_in   = '0;
    bus.pair_vld  = 1'b0;
    bus.pair_last = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_ties();
    test_hold_single();
    test_reset_drain();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
